// File: rtl/lcd_rx_decoder_if.sv
// LCD parallel bus as seen by the receiver: strobe, register select, read/write
// and the upper data nibble D7..D4.
interface lcd_rx_decoder_if;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [3:0] lcd_d;

  modport master (output lcd_e, lcd_rs, lcd_rw, lcd_d);
  modport slave  (input  lcd_e, lcd_rs, lcd_rw, lcd_d);
endinterface

// File: rtl/lcd_rx_decoder.sv
// HD44780-style bus receiver: synchronizes the LCD bus, pairs nibbles in 4-bit mode,
// decodes commands and maintains a 128-byte DDRAM shadow with a registered read port.
module lcd_rx_decoder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CLEAR_CHAR  = 8'h20
) (
  input  logic              CLK,
  input  logic              rst_p,
  lcd_rx_decoder_if.slave   bus,
  input  logic [6:0]        rd_addr,
  output logic [7:0]        rd_data,
  output logic              char_valid,
  output logic [7:0]        char_data,
  output logic [6:0]        char_addr,
  output logic              cmd_valid,
  output logic [7:0]        cmd_data,
  output logic              mode_4bit,
  output logic              busy,
  output logic              err_overrun
);

  localparam logic [1:0] INIT8 = 2'd0;
  localparam logic [1:0] HI    = 2'd1;
  localparam logic [1:0] LO    = 2'd2;
  localparam logic [1:0] CLR   = 2'd3;

  // Bus packed as {e, rs, rw, d[3:0]} so all lines share one synchronizer chain.
  logic [6:0] bus_in;
  logic [6:0] sync_reg [SYNC_STAGES];
  logic [6:0] sync_out;
  logic       e_prev_reg;
  logic       strobe;

  assign bus_in   = {bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.lcd_d};
  assign sync_out = sync_reg[SYNC_STAGES-1];
  // Read cycles are not strobes at all.
  assign strobe   = e_prev_reg & ~sync_out[6] & ~sync_out[4];

  always_ff @(posedge CLK) begin
    if (rst_p) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
    end else begin
      sync_reg[0] <= bus_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
    end
  end

  logic [1:0] state_reg;
  logic [6:0] addr_reg;
  logic       id_reg;
  logic       mode_reg;
  logic       busy_reg;
  logic       err_reg;
  logic [3:0] hi_nib_reg;
  logic       hi_rs_reg;
  logic [6:0] clr_cnt_reg;
  logic       char_valid_reg;
  logic [7:0] char_data_reg;
  logic [6:0] char_addr_reg;
  logic       cmd_valid_reg;
  logic [7:0] cmd_data_reg;
  logic [7:0] byte_val;

  assign byte_val = {hi_nib_reg, sync_out[3:0]};

  logic [7:0] mem [128];
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = addr_reg;
    wr_data = byte_val;
    if (state_reg == LO && strobe && hi_rs_reg) begin
      wr_en = 1'b1;
    end else if (state_reg == CLR && busy_reg) begin
      wr_en   = 1'b1;
      wr_addr = clr_cnt_reg;
      wr_data = CLEAR_CHAR;
    end
    if (rst_p) wr_en = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

  always_ff @(posedge CLK) begin
    if (rst_p) begin
      e_prev_reg     <= 1'b0;
      state_reg      <= INIT8;
      addr_reg       <= '0;
      id_reg         <= 1'b1;
      mode_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      err_reg        <= 1'b0;
      hi_nib_reg     <= '0;
      hi_rs_reg      <= 1'b0;
      clr_cnt_reg    <= '0;
      char_valid_reg <= 1'b0;
      char_data_reg  <= '0;
      char_addr_reg  <= '0;
      cmd_valid_reg  <= 1'b0;
      cmd_data_reg   <= '0;
    end else begin
      e_prev_reg     <= sync_out[6];
      char_valid_reg <= 1'b0;
      cmd_valid_reg  <= 1'b0;
      case (state_reg)
        INIT8: begin
          if (strobe && !sync_out[5] && sync_out[3:0] == 4'h2) begin
            state_reg <= HI;
            mode_reg  <= 1'b1;
          end
        end
        HI: begin
          if (strobe) begin
            hi_nib_reg <= sync_out[3:0];
            hi_rs_reg  <= sync_out[5];
            state_reg  <= LO;
          end
        end
        LO: begin
          if (strobe) begin
            state_reg <= HI;
            if (hi_rs_reg) begin
              char_valid_reg <= 1'b1;
              char_data_reg  <= byte_val;
              char_addr_reg  <= addr_reg;
              addr_reg       <= id_reg ? addr_reg + 7'd1 : addr_reg - 7'd1;
            end else begin
              cmd_valid_reg <= 1'b1;
              cmd_data_reg  <= byte_val;
              // Highest set bit selects the command.
              casez (byte_val)
                8'b1???_????: addr_reg <= byte_val[6:0];
                8'b01??_????: ;
                8'b001?_????: begin
                  if (byte_val[4]) begin
                    state_reg <= INIT8;
                    mode_reg  <= 1'b0;
                  end
                end
                8'b0001_????: ;
                8'b0000_1???: ;
                8'b0000_01??: id_reg    <= byte_val[1];
                8'b0000_001?: addr_reg  <= '0;
                8'b0000_0001: state_reg <= CLR;
                default: ;
              endcase
            end
          end
        end
        CLR: begin
          if (strobe) err_reg <= 1'b1;
          // One idle cycle before the fill keeps busy off the cmd_valid cycle.
          if (!busy_reg) begin
            busy_reg    <= 1'b1;
            clr_cnt_reg <= '0;
          end else begin
            clr_cnt_reg <= clr_cnt_reg + 7'd1;
            if (clr_cnt_reg == 7'h7F) begin
              busy_reg  <= 1'b0;
              addr_reg  <= '0;
              id_reg    <= 1'b1;
              state_reg <= HI;
            end
          end
        end
        default: state_reg <= INIT8;
      endcase
    end
  end

  assign char_valid  = char_valid_reg;
  assign char_data   = char_data_reg;
  assign char_addr   = char_addr_reg;
  assign cmd_valid   = cmd_valid_reg;
  assign cmd_data    = cmd_data_reg;
  assign mode_4bit   = mode_reg;
  assign busy        = busy_reg;
  assign err_overrun = err_reg;

endmodule

// File: doc/lcd_rx_decoder.md
LCD_RX_DECODER -- requirements
Module: lcd_rx_decoder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on lcd_e, lcd_rs, lcd_rw and lcd_d; legal values 2-3.
REQ-002 Parameter CLEAR_CHAR, default 8'h20: fill value written to every DDRAM location on a Clear Display command.
REQ-003 Port CLK, input, 1: sole clock; all state updates on the rising edge.
REQ-004 Port rst_p, input, 1: reset, synchronous and active-high.
REQ-005 Port lcd_e, input, 1: LCD enable strobe from the bus initiator; asynchronous to CLK.
REQ-006 Port lcd_rs, input, 1: register select (0 = command, 1 = data).
REQ-007 Port lcd_rw, input, 1: 1 = read cycle.
REQ-008 Port lcd_d, input, 4: data nibble (bus lines D7..D4).
REQ-009 Port rd_addr, input, 7: DDRAM read address.
REQ-010 Port rd_data, output, 8: DDRAM contents at rd_addr, registered.
REQ-011 Port char_valid, output, 1: one-cycle pulse per character written.
REQ-012 Port char_data, output, 8: character byte, valid with char_valid.
REQ-013 Port char_addr, output, 7: DDRAM address written, valid with char_valid.
REQ-014 Port cmd_valid, output, 1: one-cycle pulse per command byte decoded in 4-bit mode.
REQ-015 Port cmd_data, output, 8: command byte, valid with cmd_valid.
REQ-016 Port mode_4bit, output, 1: high once 4-bit nibble pairing is active.
REQ-017 Port busy, output, 1: high while a Clear Display fill is in progress.
REQ-018 Port err_overrun, output, 1: sticky flag, set when a strobe is dropped while busy.

Function
REQ-019 lcd_e, lcd_rs, lcd_rw and lcd_d shall pass through SYNC_STAGES flops; a strobe is the cycle in which synchronized lcd_e goes from 1 to 0, with rs, rw and d sampled from the same synchronized stage.
REQ-020 Strobes with rw = 1 shall be ignored entirely (no state change, no pulses).
REQ-021 State machine states: INIT8, HI, LO, CLR.
REQ-022 INIT8: each strobe is a single nibble; rs = 0 with nibble 4'h2 moves to HI and sets mode_4bit; all other nibbles are discarded.
REQ-023 HI: a strobe latches the nibble as byte[7:4] plus rs, then moves to LO.
REQ-024 LO: a strobe forms the byte {hi, nibble}; the byte is acted on and the state moves to HI (or to CLR on Clear Display); an rs value different from the HI nibble's rs shall use the HI nibble's rs.
REQ-025 Data byte (rs = 1): write to DDRAM[addr]; the cycle after the LO strobe, pulse char_valid with char_data/char_addr; then addr += 1 if ID = 1, else addr -= 1, modulo 128.
REQ-026 Command byte (rs = 0): the cycle after the LO strobe, pulse cmd_valid with cmd_data, then decode with the highest set bit deciding: 8'h01 Clear; 8'h02/8'h03 Home (addr = 0); 8'b0000_01xx Entry (ID = bit 1); 8'b1xxx_xxxx Set Address (addr = byte[6:0]); 8'b001x_xxxx Function Set, where DL = bit 4 = 1 returns to INIT8 and clears mode_4bit and DL = 0 has no effect; all others are ignored.
REQ-027 CLR: busy = 1; write CLEAR_CHAR to locations 0..127, one per cycle (128 cycles); then addr = 0, ID = 1, busy = 0, and the state moves to HI.
REQ-028 A strobe during CLR shall be dropped and set err_overrun; err_overrun clears only on reset.
REQ-029 rd_data shall equal DDRAM[rd_addr] one cycle after rd_addr is presented; a same-cycle write to that address returns the old value.
REQ-030 char_valid and cmd_valid shall never assert in the same cycle and shall never assert while busy.

Reset
REQ-031 On rst_p high at a rising CLK edge: state = INIT8, addr = 0, ID = 1, mode_4bit = 0, busy = 0, err_overrun = 0, char_valid = 0, cmd_valid = 0, char_data = 0, char_addr = 0, cmd_data = 0, and synchronizers cleared to 0.
REQ-032 DDRAM contents are not reset; reset mid-operation (including during CLR) shall abort immediately, with no further writes.

Verification
REQ-033 Init nibbles 3, 3, 3, 2 (rs = 0) -> mode_4bit = 1 after the fourth strobe; no cmd_valid pulses.
REQ-034 After init, data nibbles 5, 4 (rs = 1) -> char_valid with char_data = 8'h54 and char_addr = 0; next char_addr = 1.
REQ-035 Command 8'hC0, then data 8'h50 -> cmd_valid with cmd_data = 8'hC0; char_addr = 7'h40; rd_addr = 7'h40 gives rd_data = 8'h50.
REQ-036 Command 8'h04, address 8'h80, then two chars -> char_addr 0 then 7'h7F (wrap-around).
REQ-037 Command 8'h01 -> busy high 128 cycles; all locations read 8'h20; a strobe mid-clear sets err_overrun.
REQ-038 rst_p asserted mid-clear, and a rw = 1 strobe after init -> state INIT8 with all flags 0; the rw = 1 strobe produces no pulse and no address change.
